// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants, state and unit-select types for the multi-cycle stall controller
package mc_pkg;

  localparam int M_EXT_BIT = 4;
  localparam int DIV_BIT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  typedef enum logic {
    UNIT_DIV = 1'b0,
    UNIT_MUL = 1'b1
  } unit_sel_e;

  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multicycle_stall_ctrl_if.sv
// rtl/multicycle_stall_ctrl_if.sv - EX-stage decode inputs and stall/sequencing outputs of the controller
interface multicycle_stall_ctrl_if;
  logic [4:0]  AluControlPort;
  logic        ex_valid_i;
  logic        flush_i;
  logic        stall_o;
  logic        op_start_o;
  logic        unit_sel_o;
  logic        result_valid_o;
  logic        div_aresetn_o;
  logic        busy_o;
  logic [31:0] stall_cycles_o;

  modport master (
    output AluControlPort, ex_valid_i, flush_i,
    input  stall_o, op_start_o, unit_sel_o, result_valid_o, div_aresetn_o, busy_o, stall_cycles_o
  );

  modport slave (
    input  AluControlPort, ex_valid_i, flush_i,
    output stall_o, op_start_o, unit_sel_o, result_valid_o, div_aresetn_o, busy_o, stall_cycles_o
  );
endinterface

// File: rtl/mc_latency_counter.sv
// rtl/mc_latency_counter.sv - loadable down-counter with one/zero flags; load wins over decrement
module mc_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one,
  output logic             is_zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      // never wraps below zero; the FSM treats a zero count in BUSY as an abort
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt     = cnt_q;
  assign is_one  = (cnt_q == CNT_W'(1));
  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/multicycle_stall_ctrl.sv
// rtl/multicycle_stall_ctrl.sv - freezes IF/ID/EX for the latency of DIV/REM (optionally MUL) and sequences the unit
// Optional stall-cycle performance counter enabled by defining MC_STALL_PERF_EN.
module multicycle_stall_ctrl
  import mc_pkg::*;
#(
  parameter int DIV_LATENCY    = 9,
  parameter int MUL_LATENCY    = 3,
  parameter int MUL_MULTICYCLE = 0
) (
  input  logic                   clk,
  input  logic                   aresetn,
  multicycle_stall_ctrl_if.slave bus
);

  localparam int   CNT_W        = $clog2(lat_max(DIV_LATENCY, MUL_LATENCY) + 1);
  localparam logic MUL_MC_EN    = (MUL_MULTICYCLE != 0);
  localparam logic DIV_LAT_ONE  = (DIV_LATENCY == 1);
  localparam logic MUL_LAT_ONE  = (MUL_LATENCY == 1);

  logic [4:0]       alu;
  logic             is_div;
  logic             mc_op;
  logic             lat_one;
  logic [CNT_W-1:0] lat_m1;
  logic             unused_alu;

  assign alu        = bus.AluControlPort;
  assign is_div     = alu[DIV_BIT];
  assign mc_op      = bus.ex_valid_i & alu[M_EXT_BIT] & (is_div | MUL_MC_EN);
  assign lat_one    = is_div ? DIV_LAT_ONE : MUL_LAT_ONE;
  assign lat_m1     = is_div ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
  assign unused_alu = ^{alu[3], alu[1:0]};

  mc_state_e        state_q, state_d;
  unit_sel_e        unit_sel_q;
  logic             result_valid_q;
  logic             div_aresetn_q;
  logic             stall;
  logic             start;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_one;
  logic             cnt_zero;
  logic             div_end;

  mc_latency_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (aresetn),
    .load     (cnt_load),
    .load_val (lat_m1),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .is_one   (cnt_one),
    .is_zero  (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    start    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mc_op && !bus.flush_i) begin
          stall    = 1'b1;
          start    = 1'b1;
          cnt_load = 1'b1;
          state_d  = lat_one ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (bus.flush_i || cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_one) state_d = ST_DONE;
        end
      end
      // the finished op is still visible in EX here; it must not retrigger
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign div_end = (unit_sel_q == UNIT_DIV) &&
                   ((state_q == ST_DONE) || ((state_q == ST_BUSY) && bus.flush_i));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      unit_sel_q     <= UNIT_DIV;
      result_valid_q <= 1'b0;
      div_aresetn_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_valid_q <= (state_d == ST_DONE);
      div_aresetn_q  <= ~div_end;
      if (start) unit_sel_q <= is_div ? UNIT_DIV : UNIT_MUL;
    end
  end

  // combinational outputs are masked by reset so every output shows its reset value immediately
  assign bus.stall_o        = stall & aresetn;
  assign bus.op_start_o     = start & aresetn;
  assign bus.unit_sel_o     = unit_sel_q;
  assign bus.result_valid_o = result_valid_q;
  assign bus.div_aresetn_o  = div_aresetn_q;
  assign bus.busy_o         = (state_q != ST_IDLE);

`ifdef MC_STALL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      perf_q <= 32'd0;
    end else if (bus.stall_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.stall_cycles_o = perf_q;
`else
  assign bus.stall_cycles_o = 32'd0;
`endif

endmodule
